mdu_iter32: RTL

- Iterative 32-bit multiply/divide unit for the CPU datapath.
- Owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU over multiple cycles, with a start/busy/done handshake.
- Its hi/lo outputs feed the 32-bit 2:1 result-select muxes in the writeback path (MFHI/MFLO vs ALU result).
- Also serves MTHI/MTLO writes.

---
 rtl/mdu_iter32.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mdu_iter32.sv
// mdu_iter32: iterative 32-bit multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per cycle.
// The datapath works on operand magnitudes; sign correction is applied in FIN.
module mdu_iter32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   busy_nxt, done_nxt;
    logic   accept;

    // Latched operation context
    logic             op_div;
    logic             neg_lo;     // negate product (mul) or quotient (div)
    logic             neg_hi;     // negate remainder (dividend was negative)
    logic             div_zero;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] opnd;       // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] acc_hi;     // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier shifting out / quotient shifting in
    logic [CW-1:0]    cnt;

    // Operand magnitudes and signs
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // One-iteration results
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi, div_lo;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    // Final sign-corrected results
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign accept = (state == IDLE) && start;

    // Sign extraction and magnitude of the incoming operands
    always_comb begin
        a_neg = op[0] & a[WIDTH-1];
        b_neg = op[0] & b[WIDTH-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // State register plus registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: values the busy/done registers take at the next edge
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == FIN);
    end

    // Single iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_lo    = {acc_lo[WIDTH-2:0], div_ge};
        iter_hi   = op_div ? div_hi : mul_hi;
        iter_lo   = op_div ? div_lo : mul_lo;
    end

    // Operand latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            raw_a    <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
        end else if (accept) begin
            op_div   <= op[1];
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            div_zero <= (b == '0);
            raw_a    <= a;
            opnd     <= op[1] ? b_mag : a_mag;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_mag : b_mag;
            cnt      <= '0;
        end else if (state == CALC) begin
            acc_hi   <= iter_hi;
            acc_lo   <= iter_lo;
            cnt      <= cnt + 1'b1;
        end
    end

    // Sign correction and divide-by-zero override
    always_comb begin
        prod_s = neg_lo ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
        quo_s  = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
        rem_s  = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
        if (!op_div) begin
            fin_hi = prod_s[2*WIDTH-1:WIDTH];
            fin_lo = prod_s[WIDTH-1:0];
        end else if (div_zero) begin
            fin_hi = raw_a;
            fin_lo = '1;
        end else begin
            fin_hi = rem_s;
            fin_lo = quo_s;
        end
    end

    // HI/LO: result write in FIN, MTHI/MTLO only when idle with no start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIN) begin
            hi <= fin_hi;
            lo <= fin_lo;
        end else if ((state == IDLE) && !start) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

endmodule
